// File: rtl/idex_skid_pipe_reg.sv
// ID/EX pipeline register with valid/ready handshake and a 2-entry skid
// buffer. in_ready is a flop, so EX back-pressure never forms a
// combinational path into ID. Flush drops everything held plus the offer
// in the same cycle. The outgoing control becomes a bubble (all zero), and
// the payload keeps its last value.
// Optional feature: define PIPE_PERF_CNT_EN to add saturating stall/kill
// counters (stall_cnt, kill_cnt ports).
module idex_skid_pipe_reg #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 160,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  kill_cnt
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              in_ready_q, out_valid_q;
  logic [1:0]        occ_q;
  logic [CTRL_W-1:0] head_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0] head_data_q, skid_data_q;

  logic accept, fire;
  logic ld_head_in, ld_skid_in, ld_head_skid;

  assign accept = in_valid & in_ready_q & ~flush;
  assign fire   = out_valid_q & out_ready;

  // Next state and which register loads from where; flush overrides all
  always_comb begin
    state_d      = state_q;
    ld_head_in   = 1'b0;
    ld_skid_in   = 1'b0;
    ld_head_skid = 1'b0;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: if (accept) begin
          state_d    = S_ONE;
          ld_head_in = 1'b1;
        end
        S_ONE: begin
          if (accept && fire) begin
            ld_head_in = 1'b1;
          end else if (accept) begin
            state_d    = S_FULL;
            ld_skid_in = 1'b1;
          end else if (fire) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: if (fire) begin
          state_d      = S_ONE;
          ld_head_skid = 1'b1;
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // State, registered handshake outputs and entry storage
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
      head_ctrl_q <= '0;
      head_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != S_FULL);
      out_valid_q <= (state_d != S_EMPTY);
      occ_q       <= state_d;
      if (ld_head_in) begin
        head_ctrl_q <= in_ctrl;
        head_data_q <= in_data;
      end else if (ld_head_skid) begin
        head_ctrl_q <= skid_ctrl_q;
        head_data_q <= skid_data_q;
      end
      if (ld_skid_in) begin
        skid_ctrl_q <= in_ctrl;
        skid_data_q <= in_data;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_ctrl  = out_valid_q ? head_ctrl_q : '0;
  assign out_data  = head_data_q;
  assign occupancy = occ_q;

`ifdef PIPE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] stall_q, kill_q;
  logic [1:0]       kill_add;
  logic [CNT_W:0]   kill_sum;

  // Held entries not consumed this cycle plus an offer that could have been taken
  assign kill_add = flush ? (occ_q - {1'b0, fire} + {1'b0, in_valid & in_ready_q}) : 2'd0;
  assign kill_sum = {1'b0, kill_q} + (CNT_W+1)'(kill_add);

  // Saturating counters; flush leaves them alone
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      kill_q  <= '0;
    end else begin
      if (out_valid_q && !out_ready && stall_q != CNT_MAX)
        stall_q <= stall_q + 1'b1;
      kill_q <= kill_sum[CNT_W] ? CNT_MAX : kill_sum[CNT_W-1:0];
    end
  end

  assign stall_cnt = stall_q;
  assign kill_cnt  = kill_q;
`endif

endmodule

// File: tb/tb_idex_skid_pipe_reg.sv
// Bench for idex_skid_pipe_reg: table-driven directed vectors, hand
// sequences for the flush/reset/saturation cases, and random traffic, all
// checked each cycle against a queue-based reference model.
module tb_idex_skid_pipe_reg;
  localparam int CW = 16;
  localparam int DW = 32;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
`ifdef PIPE_PERF_CNT_EN
  logic [NW-1:0] stall_cnt, kill_cnt;
`endif

  idex_skid_pipe_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .kill_cnt(kill_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: a FIFO of at most two entries
  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;
  ent_t          mq[$];
  logic [DW-1:0] m_last = '0;
  int            m_stall = 0, m_kill = 0;
  localparam int SAT = (1 << NW) - 1;

  task automatic model_update();
    bit can_take, took_out;
    int n;
    if (reset) begin
      mq.delete();
      m_last = '0; m_stall = 0; m_kill = 0;
      return;
    end
    n = mq.size();
    can_take = (n < 2);
    took_out = (n > 0) && out_ready;
    if (n > 0 && !out_ready) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
    if (flush) begin
      m_kill += (n - int'(took_out)) + int'(in_valid && can_take);
      if (m_kill > SAT) m_kill = SAT;
      mq.delete();
    end else begin
      if (took_out) void'(mq.pop_front());
      if (in_valid && can_take) mq.push_back('{c: in_ctrl, d: in_data});
    end
    if (mq.size() > 0) m_last = mq[0].d;
  endtask

  task automatic model_check();
    chk("out_valid", out_valid, mq.size() > 0);
    chk("out_ctrl", out_ctrl, mq.size() > 0 ? mq[0].c : '0);
    chk("out_data", out_data, m_last);
    chk("occupancy", occupancy, mq.size());
    chk("in_ready", in_ready, mq.size() < 2);
`ifdef PIPE_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, m_stall);
    chk("kill_cnt", kill_cnt, m_kill);
`endif
  endtask

  // Drive one cycle (inputs set after negedge), update model on posedge, check at negedge
  task automatic step(input logic rst, input logic fl, input logic iv,
                      input logic [CW-1:0] c, input logic [DW-1:0] d, input logic ordy);
    reset = rst; flush = fl; in_valid = iv; in_ctrl = c; in_data = d; out_ready = ordy;
    @(posedge clk);
    model_update();
    @(negedge clk);
    model_check();
  endtask

  typedef struct {
    logic          fl, iv, ordy;
    logic [CW-1:0] c;
    logic          e_vld, e_rdy;
    logic [CW-1:0] e_ctrl;
    logic [DW-1:0] e_data;
    logic [1:0]    e_occ;
  } vec_t;

  vec_t vt[18];

  function automatic vec_t v(logic fl, logic iv, logic [CW-1:0] c, logic ordy,
                             logic ev, logic [CW-1:0] ec, logic [DW-1:0] ed,
                             logic [1:0] eo, logic er);
    vec_t r;
    r.fl = fl; r.iv = iv; r.c = c; r.ordy = ordy;
    r.e_vld = ev; r.e_ctrl = ec; r.e_data = ed; r.e_occ = eo; r.e_rdy = er;
    return r;
  endfunction

  initial begin
    // Payload for each row is 32'hD000 + ctrl
    vt[0]  = v(0,1,16'h1,1, 1,16'h1,32'hD001,1,1);
    vt[1]  = v(0,1,16'h2,1, 1,16'h2,32'hD002,1,1);
    vt[2]  = v(0,1,16'h3,1, 1,16'h3,32'hD003,1,1);
    vt[3]  = v(0,1,16'h4,1, 1,16'h4,32'hD004,1,1);
    vt[4]  = v(0,1,16'h5,1, 1,16'h5,32'hD005,1,1);
    vt[5]  = v(0,0,16'h0,1, 0,16'h0,32'hD005,0,1);
    vt[6]  = v(0,1,16'hA,0, 1,16'hA,32'hD00A,1,1);
    vt[7]  = v(0,1,16'hB,0, 1,16'hA,32'hD00A,2,0);
    vt[8]  = v(0,1,16'hC,0, 1,16'hA,32'hD00A,2,0);
    vt[9]  = v(0,1,16'hC,1, 1,16'hB,32'hD00B,1,1);
    vt[10] = v(0,1,16'hC,1, 1,16'hC,32'hD00C,1,1);
    vt[11] = v(0,0,16'h0,1, 0,16'h0,32'hD00C,0,1);
    vt[12] = v(0,1,16'hE,0, 1,16'hE,32'hD00E,1,1);
    vt[13] = v(0,1,16'hF,0, 1,16'hE,32'hD00E,2,0);
    vt[14] = v(1,1,16'h77,0, 0,16'h0,32'hD00E,0,1);
    vt[15] = v(0,1,16'h10,0, 1,16'h10,32'hD010,1,1);
    vt[16] = v(1,1,16'hD,0, 0,16'h0,32'hD010,0,1);
    vt[17] = v(0,0,16'h0,1, 0,16'h0,32'hD010,0,1);

    // Reset held two cycles while ID offers
    @(negedge clk);
    step(1, 0, 1, 16'h55, 32'h55, 0);
    step(1, 0, 1, 16'h66, 32'h66, 0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_ctrl", out_ctrl, '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_occ", occupancy, 2'd0);

    // Directed table: stream, skid fill/drain, flush in FULL and ONE
    for (int i = 0; i < 18; i++) begin
      step(0, vt[i].fl, vt[i].iv, vt[i].c, 32'hD000 + DW'(vt[i].c), vt[i].ordy);
      chk($sformatf("vec%0d_valid", i), out_valid, vt[i].e_vld);
      chk($sformatf("vec%0d_ctrl", i), out_ctrl, vt[i].e_ctrl);
      chk($sformatf("vec%0d_data", i), out_data, vt[i].e_data);
      chk($sformatf("vec%0d_occ", i), occupancy, vt[i].e_occ);
      chk($sformatf("vec%0d_ready", i), in_ready, vt[i].e_rdy);
    end
`ifdef PIPE_PERF_CNT_EN
    chk("tbl_kill_cnt", kill_cnt, 4);
    chk("tbl_stall_cnt", stall_cnt, 5);
`endif

    // Reset in the middle of a FULL buffer discards everything
    step(0, 0, 1, 16'h21, 32'h21, 0);
    step(0, 0, 1, 16'h22, 32'h22, 0);
    chk("full_occ", occupancy, 2'd2);
    step(1, 0, 1, 16'h23, 32'h23, 1);
    chk("rst_full_valid", out_valid, 1'b0);
    chk("rst_full_ctrl", out_ctrl, '0);
    chk("rst_full_data", out_data, '0);
    chk("rst_full_occ", occupancy, 2'd0);
    chk("rst_full_ready", in_ready, 1'b1);
    // Skid contents were cleared too: draining after one accept shows only the new entry
    step(0, 0, 1, 16'h31, 32'h31, 0);
    step(0, 0, 0, 16'h0, 32'h0, 1);
    chk("post_rst_empty", occupancy, 2'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 3) != 0), CW'($urandom), $urandom,
           ($urandom_range(0, 2) != 0));
    end

    // Stall counter saturation: one held entry, EX stalls for 20 cycles
    step(1, 0, 0, 16'h0, 32'h0, 0);
    step(0, 0, 1, 16'h40, 32'h40, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 16'h0, 32'h0, 0);
`ifdef PIPE_PERF_CNT_EN
    chk("stall_sat", stall_cnt, 4'hF);
`endif
    chk("stall_hold_ctrl", out_ctrl, 16'h40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
